core_fetch_queue: RTL
=====================

# core_fetch_queue

Parametrised instruction-fetch front end with a DEPTH-entry prefetch queue. It decouples the instruction bus from the ID stage: it issues sequential word fetches ahead of consumption and buffers the returned (pc, instr) pairs. On a redirect it flushes the queue and discards any in-flight response. It sits between the instruction-side bus master and the ID-stage decoder, and replaces single-entry PC/instruction latching with a queue the decoder pops.

## Interface
Parameters:
- DEPTH, 4, number of queue entries; power of two, ≥2. Full 1-instr/cycle throughput requires ≥3.
- CNT_W, $clog2(DEPTH+1), width of o_count. Derived; do not override.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_boot_addr  in  32  first fetch address after reset; quasi-static.
- i_redirect  in  1  flush and restart fetch at i_redirect_target.
- i_redirect_target  in  32  new fetch PC; bits [1:0] ignored (treated as 0).
- i_deq  in  1  consumer pops the head entry this cycle.
- o_valid  out  1  head entry present.
- o_pc  out  32  PC of the head entry; 0 when !o_valid.
- o_instr  out  32  instruction word of the head entry; 0 when !o_valid.
- o_count  out  CNT_W  occupied entries, 0..DEPTH.
- o_rd_req  out  1  instruction-bus read request.
- o_rd_addr  out  32  read address (= fpc).
- i_rd_gnt  in  1  grant; same cycle as o_rd_req. Ignored when o_rd_req=0.
- i_rd_data  in  32  read data; valid the cycle after a grant.

## Operation
- State:
  - fpc: 32-bit fetch PC.
  - run: 1-bit, reset 0, set to 1 at the first clock edge after reset release.
  - inflight: 1-bit, set by a grant, cleared the following cycle.
  - Circular buffer of DEPTH {pc, instr} entries, with head pointer, tail pointer and count.
- Request rule: o_rd_req = run & ~i_redirect & (count + inflight < DEPTH); o_rd_addr = fpc.
- Accepted request (o_rd_req & i_rd_gnt):
  - fpc ← fpc + 4, wrapping modulo 2^32.
  - inflight ← 1.
  - The granted address is retained as resp_pc.
- Response (inflight, no redirect this cycle): write {resp_pc, i_rd_data} at tail; tail and count advance.
- Dequeue (i_deq & o_valid & no redirect): head advances, count decrements.
  - i_deq while empty is ignored.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance. The queue is never written when full, because the request rule prevents it.
- Redirect (i_redirect=1), with priority over everything else:
  - Next cycle: count=0, head=tail=0, o_valid=0.
  - fpc ← {i_redirect_target[31:2], 2'b00}.
  - A response arriving in the redirect cycle is dropped; inflight clears.
  - No request is issued in the redirect cycle.
- Back-to-back redirects: the last one wins. Fetch resumes the cycle after the final redirect.
- Pointers are log2(DEPTH) bits and wrap naturally. count is kept separately, so full and empty are unambiguous.

## Timing
- Reset values:
  - o_valid=0, o_pc=0, o_instr=0, o_count=0.
  - o_rd_req=0 (run=0), o_rd_addr=i_boot_addr with [1:0] forced to 0.
  - inflight=0, pointers=0.
- Reset asserted mid-operation: all state returns to reset values immediately, asynchronously. An in-flight response is lost.
- Cycle R is the first rising edge with rst_n high; run=1 afterwards. First request is in cycle R+1.
- Fetch latency: grant in cycle N, data on i_rd_data in N+1, entry visible at head (o_valid=1) in N+2. Latency is 2 cycles from grant to visibility; there is no bypass.
- Redirect in cycle N: first new request in N+1; earliest o_valid with new-stream data in N+3.
- Sustained throughput is 1 instruction/cycle when i_rd_gnt=1 continuously, i_deq=1 continuously, and DEPTH≥3.
- All outputs except o_rd_req are registered or come from a mux of registered state. o_rd_req depends combinationally on i_redirect.

## Test plan
- Reset then stream:
  - Stimulus: i_boot_addr=0x0000_1000, gnt always 1, rd_data=addr^0xFFFF, i_deq=1.
  - Response: o_pc sequence 0x1000, 0x1004, 0x1008… with o_instr matching rd_data, one per cycle from R+3. o_count settles at 1.
- Fill:
  - Stimulus: i_deq=0, gnt=1, DEPTH=4.
  - Response: o_count goes 1, 2, 3, 4 and then holds. o_rd_req=0 once count+inflight=4. Exactly 4 grants occur, with o_rd_addr advancing by 4 each time.
- Drain and refill at full:
  - Stimulus: from full, i_deq=1 for one cycle.
  - Response: o_count 4→3, o_rd_req reasserts the same cycle count=3, and count returns to 4 two cycles later. Head pc advances by 4 per pop. Pointer wrap shows no pc gaps.
- Redirect with an in-flight response:
  - Stimulus: grant at 0x2000 in cycle N; redirect to 0x3002 in N+1.
  - Response: the 0x2000 data is dropped; o_valid=0 in N+2; next o_rd_addr=0x3000 in N+2; first o_pc=0x3000.
- Redirect with simultaneous deq on a full queue:
  - Response: o_count=0 next cycle, o_valid=0, o_pc=o_instr=0; no stale entry is ever presented.
- Bus stalls and empty-queue deq:
  - Stimulus: gnt=0 for 5 cycles while o_rd_req=1; i_deq=1 while empty.
  - Response: o_rd_addr is held constant, fpc does not advance, o_count stays 0, and i_deq is ignored.

Source files
------------

// File: rtl/core_fetch_queue.sv
// core_fetch_queue: instruction-fetch front end with a DEPTH-entry prefetch queue.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_boot_addr                first fetch address after reset (bits [1:0] ignored)
//   i_redirect, i_redirect_target  flush queue and restart fetch at target
//   i_deq                      consumer pops the head entry
//   o_valid, o_pc, o_instr     head entry (pc/instr are 0 when empty)
//   o_count                    occupied entries, 0..DEPTH
//   o_rd_req, o_rd_addr        instruction-bus read request and address
//   i_rd_gnt, i_rd_data        grant (same cycle as request), data (cycle after grant)
module core_fetch_queue #(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH+1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      i_boot_addr,
   input  logic             i_redirect,
   input  logic [31:0]      i_redirect_target,
   input  logic             i_deq,
   output logic             o_valid,
   output logic [31:0]      o_pc,
   output logic [31:0]      o_instr,
   output logic [CNT_W-1:0] o_count,
   output logic             o_rd_req,
   output logic [31:0]      o_rd_addr,
   input  logic             i_rd_gnt,
   input  logic [31:0]      i_rd_data
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] L_FULL   = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] L_ALMOST = CNT_W'(DEPTH-1);

   logic [31:0]      r_fpc;
   logic [31:0]      r_resp_pc;
   logic             r_run;
   logic             r_inflight;
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;
   logic [31:0]      r_pc_mem    [DEPTH];
   logic [31:0]      r_instr_mem [DEPTH];

   logic [31:0] w_boot;
   logic        w_req;
   logic        w_acc;
   logic        w_wr;
   logic        w_rd;

   // An in-flight response already owns one slot, so it counts against capacity.
   always_comb begin
      w_boot    = {i_boot_addr[31:2], 2'b00};
      w_req     = r_run & ~i_redirect & (r_inflight ? (r_count < L_ALMOST) : (r_count < L_FULL));
      w_acc     = w_req & i_rd_gnt;
      w_wr      = r_inflight & ~i_redirect;
      o_valid   = r_count != '0;
      w_rd      = i_deq & o_valid & ~i_redirect;
      o_pc      = o_valid ? r_pc_mem[r_head] : '0;
      o_instr   = o_valid ? r_instr_mem[r_head] : '0;
      o_count   = r_count;
      o_rd_req  = w_req;
      // Before run is set, fpc has not yet captured the boot address.
      o_rd_addr = r_run ? r_fpc : w_boot;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_run      <= 1'b0;
         r_inflight <= 1'b0;
         r_fpc      <= '0;
         r_resp_pc  <= '0;
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
      end else begin
         r_run      <= 1'b1;
         r_inflight <= w_acc;
         if (i_redirect)
            r_fpc <= {i_redirect_target[31:2], 2'b00};
         else if (!r_run)
            r_fpc <= w_boot;
         else if (w_acc)
            r_fpc <= r_fpc + 32'd4;
         if (w_acc)
            r_resp_pc <= r_fpc;
         if (i_redirect) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
         end else begin
            if (w_wr)
               r_tail <= r_tail + PTR_W'(1);
            if (w_rd)
               r_head <= r_head + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_wr) - CNT_W'(w_rd);
         end
      end
   end

   // Storage needs no reset: entries are only visible while count covers them.
   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_pc_mem[r_tail]    <= r_resp_pc;
         r_instr_mem[r_tail] <= i_rd_data;
      end
   end
endmodule
